id_exe_pipe_skid: RTL and testbench
===================================

// Module: id_exe_pipe_skid
// PURPOSE
//   Parametrised ID->EXE pipeline register with a valid/ready handshake and a 2-entry skid buffer.
//   It sits between decode/regfile-read and the ALU. The EXE stage can stall, and a
//   branch/exception can flush, without any combinational ready path from EXE back to ID.
//   It carries the ALU controls, both operands, the sign-extended immediate, source indices and
//   the destination register. An optional WB bypass refreshes stale operands while they are held.
// PARAMETERS
//   DSIZE   32  operand data width (rdata1/rdata2/wb_wdata)
//   ISIZE   32  extended-immediate width
//   AOP_W   3   ALU opcode width
//   RA_W    5   register address width (rs1/rs2/rd/wb_waddr)
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous reset, active high
//   flush      in   1      kill all held entries (branch/exception)
//   in_valid   in   1      ID presents a valid instruction
//   in_ready   out  1      stage can accept; registered (no comb path from out_ready)
//   alusrc_in  in   1      ALU B-source select
//   aluop_in   in   AOP_W  ALU operation
//   rdata1_in  in   DSIZE  operand A from regfile
//   rdata2_in  in   DSIZE  operand B from regfile
//   imm_in     in   ISIZE  extended immediate
//   rs1_in     in   RA_W   source index A
//   rs2_in     in   RA_W   source index B
//   rd_in      in   RA_W   destination index
//   wb_wen     in   1      WB write strobe (bypass source; used only with IDEX_WB_BYPASS_EN)
//   wb_waddr   in   RA_W   WB destination
//   wb_wdata   in   DSIZE  WB data
//   out_valid  out  1      EXE payload valid
//   out_ready  in   1      EXE consumes the payload this cycle
//   alusrc_out, aluop_out, rdata1_out, rdata2_out, imm_out, rs1_out, rs2_out, rd_out
//              out  (widths as *_in)  registered payload of the main entry
// BEHAVIOUR
//   - Storage: a main entry M (drives the outputs) and a skid entry S, each with a valid bit.
//   - in_ready = !S.valid, taken from a flop. Accept = in_valid & in_ready. Consume = out_valid & out_ready.
//   - Per-edge update, evaluated in priority order:
//     1 rst: M.valid=S.valid=0 and all payload flops 0. in_ready reads 1 and out_valid reads 0 from
//       the first cycle after reset.
//     2 flush: M.valid=S.valid=0. Any same-cycle accept is dropped. Payload flops may retain
//       stale values.
//     3 M empty: on accept, load M.
//     4 M full, consume, S empty: on accept, load M from input. With no accept, M.valid=0.
//     5 M full, consume, S full: M<=S and S.valid=0. in_ready was 0, so nothing is accepted.
//     6 M full, no consume: on accept, load S. in_ready drops next cycle.
//   - Latency: 1 cycle from accept to out_valid when empty. Full throughput is 1/cycle with
//     out_ready held high.
//   - Ordering is strictly FIFO. No entry is ever duplicated or lost, except by flush or rst.
//   - out_valid is never deasserted and payload never changes while out_valid & !out_ready, except by
//     flush/rst or the WB bypass update below.
//   - Simultaneous flush+accept: the accept is dropped. Simultaneous flush+consume: the consume
//     counts for EXE, and both entries are cleared.
// CONFIGURATION
//   IDEX_WB_BYPASS_EN defined:
//     - Condition: wb_wen and wb_waddr != 0.
//     - Capture: while the condition holds, a captured rs1_in==wb_waddr loads wb_wdata into rdata1
//       instead of rdata1_in. rs2 is handled the same way for rdata2.
//     - Held entries: every cycle, each valid entry (M, and S including during the S->M move) whose
//       rs1/rs2 matches under the condition has rdata1/rdata2 overwritten with wb_wdata.
//     - Register 0 is never bypassed.
//   IDEX_WB_BYPASS_EN undefined:
//     - wb_* ports remain but are ignored.
//     - Operands are stored exactly as captured.
// TESTING
//   - Reset: drive junk inputs with rst=1 for 2 cycles -> out_valid=0, all outputs 0, in_ready=1.
//   - Streaming: out_ready=1, send 4 instrs (rdata1=1,2,3,4) -> out_valid from cycle+1, data
//     1,2,3,4 on consecutive cycles, in_ready always 1.
//   - Stall/skid: out_ready=0, send A then B -> in_ready=0 after B; a third instr C is not accepted.
//     Raise out_ready -> A, B, C out in order with no loss.
//   - Flush: M and S full, assert flush with in_valid=1 (D) -> next cycle out_valid=0, in_ready=1,
//     D never appears at the output.
//   - Bypass (EN): hold an instr with rs1=5 stalled; pulse wb_wen, wb_waddr=5, wb_wdata=0xDEAD ->
//     rdata1_out=0xDEAD. Repeat with wb_waddr=0 -> no change. Without EN -> no change.
//   - Reset mid-stall with M and S full -> both cleared next cycle, no stale output.

Source files
------------

// File: rtl/id_exe_pipe_skid_if.sv
// id_exe_pipe_skid_if: ID->EXE handshake, payload, flush and WB bypass bus
interface id_exe_pipe_skid_if #(
  parameter int DSIZE = 32,
  parameter int ISIZE = 32,
  parameter int AOP_W = 3,
  parameter int RA_W  = 5
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic             alusrc_in;
  logic [AOP_W-1:0] aluop_in;
  logic [DSIZE-1:0] rdata1_in;
  logic [DSIZE-1:0] rdata2_in;
  logic [ISIZE-1:0] imm_in;
  logic [RA_W-1:0]  rs1_in;
  logic [RA_W-1:0]  rs2_in;
  logic [RA_W-1:0]  rd_in;
  logic             wb_wen;
  logic [RA_W-1:0]  wb_waddr;
  logic [DSIZE-1:0] wb_wdata;
  logic             out_valid;
  logic             out_ready;
  logic             alusrc_out;
  logic [AOP_W-1:0] aluop_out;
  logic [DSIZE-1:0] rdata1_out;
  logic [DSIZE-1:0] rdata2_out;
  logic [ISIZE-1:0] imm_out;
  logic [RA_W-1:0]  rs1_out;
  logic [RA_W-1:0]  rs2_out;
  logic [RA_W-1:0]  rd_out;
  modport master (
    output flush, in_valid, alusrc_in, aluop_in, rdata1_in, rdata2_in, imm_in, rs1_in, rs2_in, rd_in,
    output wb_wen, wb_waddr, wb_wdata, out_ready,
    input  in_ready, out_valid, alusrc_out, aluop_out, rdata1_out, rdata2_out, imm_out, rs1_out,
    input  rs2_out, rd_out
  );
  modport slave (
    input  flush, in_valid, alusrc_in, aluop_in, rdata1_in, rdata2_in, imm_in, rs1_in, rs2_in, rd_in,
    input  wb_wen, wb_waddr, wb_wdata, out_ready,
    output in_ready, out_valid, alusrc_out, aluop_out, rdata1_out, rdata2_out, imm_out, rs1_out,
    output rs2_out, rd_out
  );
endinterface

// File: rtl/id_exe_pipe_skid.sv
// id_exe_pipe_skid: ID->EXE register with 2-entry skid and registered ready; IDEX_WB_BYPASS_EN enables WB operand refresh
module id_exe_pipe_skid #(
  parameter int DSIZE = 32,
  parameter int ISIZE = 32,
  parameter int AOP_W = 3,
  parameter int RA_W  = 5
) (
  input logic clk,
  input logic rst,
  id_exe_pipe_skid_if.slave bus
);
  typedef struct packed {
    logic             alusrc;
    logic [AOP_W-1:0] aluop;
    logic [DSIZE-1:0] rd1;
    logic [DSIZE-1:0] rd2;
    logic [ISIZE-1:0] imm;
    logic [RA_W-1:0]  rs1;
    logic [RA_W-1:0]  rs2;
    logic [RA_W-1:0]  rd;
  } ent_t;
  ent_t m, s, in_e, in_b, m_b, s_b;
  logic m_v, s_v, hit, acc, cons;
`ifdef IDEX_WB_BYPASS_EN
  assign hit = bus.wb_wen && bus.wb_waddr != '0;
`else
  logic unused_wb;
  assign hit = 1'b0;
  assign unused_wb = bus.wb_wen;
`endif
  function automatic ent_t byp(ent_t e);
    byp = e;
    byp.rd1 = hit && e.rs1 == bus.wb_waddr ? bus.wb_wdata : e.rd1;
    byp.rd2 = hit && e.rs2 == bus.wb_waddr ? bus.wb_wdata : e.rd2;
  endfunction
  assign in_e = '{bus.alusrc_in, bus.aluop_in, bus.rdata1_in, bus.rdata2_in, bus.imm_in,
                  bus.rs1_in, bus.rs2_in, bus.rd_in};
  assign in_b = byp(in_e);
  assign m_b  = byp(m);
  assign s_b  = byp(s);
  assign acc  = bus.in_valid && !s_v;
  assign cons = m_v && bus.out_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      m_v <= 1'b0;
      s_v <= 1'b0;
      m   <= '0;
      s   <= '0;
    end else if (bus.flush) begin
      m_v <= 1'b0;
      s_v <= 1'b0;
    end else begin
      m <= m_b;
      s <= s_b;
      if (!m_v || (cons && !s_v)) begin
        m_v <= acc;
        if (acc) m <= in_b;
      end else if (cons) begin
        m   <= s_b;
        s_v <= 1'b0;
      end else if (acc) begin
        s   <= in_b;
        s_v <= 1'b1;
      end
    end
  end
  assign bus.in_ready   = !s_v;
  assign bus.out_valid  = m_v;
  assign bus.alusrc_out = m.alusrc;
  assign bus.aluop_out  = m.aluop;
  assign bus.rdata1_out = m.rd1;
  assign bus.rdata2_out = m.rd2;
  assign bus.imm_out    = m.imm;
  assign bus.rs1_out    = m.rs1;
  assign bus.rs2_out    = m.rs2;
  assign bus.rd_out     = m.rd;
endmodule

// File: tb/tb_id_exe_pipe_skid.sv
// tb_id_exe_pipe_skid: directed vectors for the ID->EXE skid register
module tb_id_exe_pipe_skid;
`ifdef IDEX_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  int n_vec = 0;
  int n_bad = 0;
  id_exe_pipe_skid_if bus ();
  id_exe_pipe_skid dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] rs);
    bus.in_valid  = v;
    bus.rdata1_in = d;
    bus.rdata2_in = ~d;
    bus.imm_in    = d << 4;
    bus.rs1_in    = rs;
    bus.rs2_in    = rs + 5'd1;
    bus.rd_in     = d[4:0];
    bus.aluop_in  = d[2:0];
    bus.alusrc_in = d[0];
  endtask
  task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    bus.wb_wen   = en;
    bus.wb_waddr = a;
    bus.wb_wdata = d;
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  initial begin
    rst = 1'b1;
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 32'hDEADBEEF, 5'd3);
    wb(1'b1, 5'd3, 32'h5555AAAA);
    tick;
    tick;
    rst = 1'b0;
    bus.flush = 1'b0;
    drive(1'b0, 32'd0, 5'd0);
    wb(1'b0, 5'd0, 32'd0);
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_rdata1", bus.rdata1_out, 32'd0);
    chk("rst_rdata2", bus.rdata2_out, 32'd0);
    chk("rst_imm", bus.imm_out, 32'd0);
    chk("rst_rd", {27'd0, bus.rd_out}, 32'd0);
    chk("rst_aluop", {29'd0, bus.aluop_out}, 32'd0);
    // streaming: each accepted word must appear the very next cycle
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, i, 5'd1);
      tick;
      chk("stream_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("stream_data", bus.rdata1_out, i);
      chk("stream_ready", {31'd0, bus.in_ready}, 32'd1);
    end
    drive(1'b0, 32'd0, 5'd0);
    tick;
    chk("stream_drain", {31'd0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b0;
    drive(1'b1, 32'd10, 5'd1);
    tick;
    chk("stall_a", bus.rdata1_out, 32'd10);
    chk("stall_ready_a", {31'd0, bus.in_ready}, 32'd1);
    drive(1'b1, 32'd11, 5'd1);
    tick;
    chk("stall_ready_b", {31'd0, bus.in_ready}, 32'd0);
    chk("stall_hold_a", bus.rdata1_out, 32'd10);
    drive(1'b1, 32'd12, 5'd1);
    tick;
    chk("stall_ready_c", {31'd0, bus.in_ready}, 32'd0);
    chk("stall_hold_a2", bus.rdata1_out, 32'd10);
    chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
    bus.out_ready = 1'b1;
    tick;
    chk("drain_b", bus.rdata1_out, 32'd11);
    chk("drain_b_rd2", bus.rdata2_out, ~32'd11);
    chk("drain_b_imm", bus.imm_out, 32'd176);
    chk("drain_ready", {31'd0, bus.in_ready}, 32'd1);
    tick;
    chk("drain_c", bus.rdata1_out, 32'd12);
    chk("drain_c_rd", {27'd0, bus.rd_out}, 32'd12);
    drive(1'b0, 32'd0, 5'd0);
    tick;
    chk("drain_empty", {31'd0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b0;
    drive(1'b1, 32'd20, 5'd1);
    tick;
    drive(1'b1, 32'd21, 5'd1);
    tick;
    bus.flush = 1'b1;
    drive(1'b1, 32'd22, 5'd1);
    tick;
    bus.flush = 1'b0;
    drive(1'b0, 32'd0, 5'd0);
    chk("flush_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_ready", {31'd0, bus.in_ready}, 32'd1);
    tick;
    chk("flush_no_d", {31'd0, bus.out_valid}, 32'd0);
    // flush while ready: the concurrent accept must vanish
    drive(1'b1, 32'd30, 5'd1);
    tick;
    bus.flush = 1'b1;
    drive(1'b1, 32'd31, 5'd1);
    tick;
    bus.flush = 1'b0;
    drive(1'b0, 32'd0, 5'd0);
    chk("flush_acc_drop", {31'd0, bus.out_valid}, 32'd0);
    tick;
    chk("flush_acc_drop2", {31'd0, bus.out_valid}, 32'd0);
    drive(1'b1, 32'd40, 5'd5);
    tick;
    drive(1'b0, 32'd0, 5'd0);
    wb(1'b1, 5'd5, 32'hDEAD);
    tick;
    wb(1'b0, 5'd0, 32'd0);
    chk("byp_m_rd1", bus.rdata1_out, BYP ? 32'hDEAD : 32'd40);
    chk("byp_m_rd2", bus.rdata2_out, ~32'd40);
    drive(1'b1, 32'd50, 5'd7);
    wb(1'b1, 5'd7, 32'hBEEF);
    tick;
    drive(1'b0, 32'd0, 5'd0);
    wb(1'b1, 5'd8, 32'h1234);
    tick;
    wb(1'b0, 5'd0, 32'd0);
    chk("byp_hold_m", bus.rdata1_out, BYP ? 32'hDEAD : 32'd40);
    bus.out_ready = 1'b1;
    tick;
    chk("byp_s_rd1", bus.rdata1_out, BYP ? 32'hBEEF : 32'd50);
    chk("byp_s_rd2", bus.rdata2_out, BYP ? 32'h1234 : ~32'd50);
    tick;
    chk("byp_empty", {31'd0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b0;
    drive(1'b1, 32'd60, 5'd0);
    tick;
    drive(1'b0, 32'd0, 5'd0);
    wb(1'b1, 5'd0, 32'hFFFF);
    tick;
    wb(1'b0, 5'd0, 32'd0);
    chk("byp_r0", bus.rdata1_out, 32'd60);
    drive(1'b1, 32'd70, 5'd1);
    tick;
    drive(1'b1, 32'd71, 5'd1);
    tick;
    chk("mid_full", {31'd0, bus.in_ready}, 32'd0);
    rst = 1'b1;
    drive(1'b0, 32'd0, 5'd0);
    tick;
    rst = 1'b0;
    chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("mid_rst_data", bus.rdata1_out, 32'd0);
    bus.out_ready = 1'b1;
    tick;
    chk("mid_rst_empty", {31'd0, bus.out_valid}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
